// File: rtl/bp_dma_arbiter.sv
// bp_dma_arbiter: shares one bsg_cache DMA port between two requesters.
// Round-robin per packet, grant held for the whole transaction, data steered
// to/from the granted requester. All data and handshake paths are combinational.
module bp_dma_arbiter #(
    parameter int unsigned dma_pkt_width_p = 33,
    parameter int unsigned data_width_p    = 64,
    parameter int unsigned block_width_p   = 512
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic [1:0][dma_pkt_width_p-1:0] req_dma_pkt_i,
    input  logic [1:0]                      req_dma_pkt_v_i,
    output logic [1:0]                      req_dma_pkt_yumi_o,

    output logic [1:0][data_width_p-1:0]    req_dma_data_o,
    output logic [1:0]                      req_dma_data_v_o,
    input  logic [1:0]                      req_dma_data_ready_and_i,

    input  logic [1:0][data_width_p-1:0]    req_dma_data_i,
    input  logic [1:0]                      req_dma_data_v_i,
    output logic [1:0]                      req_dma_data_yumi_o,

    output logic [dma_pkt_width_p-1:0]      dma_pkt_o,
    output logic                            dma_pkt_v_o,
    input  logic                            dma_pkt_yumi_i,

    input  logic [data_width_p-1:0]         dma_data_i,
    input  logic                            dma_data_v_i,
    output logic                            dma_data_ready_and_o,

    output logic [data_width_p-1:0]         dma_data_o,
    output logic                            dma_data_v_o,
    input  logic                            dma_data_yumi_i
);

    localparam int unsigned Beats = block_width_p / data_width_p;
    localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite
    } state_e;

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic             prio_q, prio_d;
    logic [BeatW-1:0] beat_q, beat_d;

    logic sel;
    logic pkt_any_v;
    logic beat_hs;

    // Arbitration and datapath steering; every valid/ready/yumi is forced low in reset.
    always_comb begin
        sel                  = req_dma_pkt_v_i[prio_q] ? prio_q : ~prio_q;
        pkt_any_v            = |req_dma_pkt_v_i;

        dma_pkt_o            = req_dma_pkt_i[sel];
        dma_pkt_v_o          = 1'b0;
        req_dma_pkt_yumi_o   = '0;

        req_dma_data_o       = {dma_data_i, dma_data_i};
        req_dma_data_v_o     = '0;
        dma_data_ready_and_o = 1'b0;

        dma_data_o           = req_dma_data_i[grant_q];
        dma_data_v_o         = 1'b0;
        req_dma_data_yumi_o  = '0;

        beat_hs              = 1'b0;

        if (!reset_i) begin
            unique case (state_q)
                StIdle: begin
                    dma_pkt_v_o             = pkt_any_v;
                    // Yumi only ever follows a valid on the selected requester.
                    req_dma_pkt_yumi_o[sel] = dma_pkt_yumi_i & pkt_any_v;
                end
                StRead: begin
                    req_dma_data_v_o[grant_q] = dma_data_v_i;
                    dma_data_ready_and_o      = req_dma_data_ready_and_i[grant_q];
                    beat_hs                   = dma_data_v_i & req_dma_data_ready_and_i[grant_q];
                end
                StWrite: begin
                    dma_data_v_o                 = req_dma_data_v_i[grant_q];
                    req_dma_data_yumi_o[grant_q] = dma_data_yumi_i & req_dma_data_v_i[grant_q];
                    beat_hs                      = dma_data_yumi_i & req_dma_data_v_i[grant_q];
                end
                default: ;
            endcase
        end
    end

    // Next-state: latch grant on packet accept, count beats, hand priority over on completion.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        beat_d  = beat_q;

        unique case (state_q)
            StIdle: begin
                if (dma_pkt_v_o && dma_pkt_yumi_i) begin
                    grant_d = sel;
                    beat_d  = '0;
                    state_d = req_dma_pkt_i[sel][dma_pkt_width_p-1] ? StWrite : StRead;
                end
            end
            StRead, StWrite: begin
                if (beat_hs) begin
                    // Beat count is a power of two, so the counter wraps to 0 on its own.
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LastBeat) begin
                        state_d = StIdle;
                        prio_d  = ~grant_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_bp_dma_arbiter.sv
// Self-checking bench for bp_dma_arbiter: 2-beat transactions, scoreboard queues
// filled by the stimulus tasks and drained by a negedge monitor.
module tb_bp_dma_arbiter;

    localparam int unsigned PktW   = 33;
    localparam int unsigned DataW  = 16;
    localparam int unsigned BlockW = 32;

    typedef struct packed {
        logic            req;
        logic [PktW-1:0] pkt;
    } pkt_exp_t;

    typedef struct packed {
        logic             req;
        logic [DataW-1:0] d;
    } beat_exp_t;

    logic                  clk_i = 1'b0;
    logic                  reset_i;
    logic [1:0][PktW-1:0]  req_pkt;
    logic [1:0]            req_pkt_v;
    logic [1:0]            req_dma_pkt_yumi_o;
    logic [1:0][DataW-1:0] req_dma_data_o;
    logic [1:0]            req_dma_data_v_o;
    logic [1:0]            req_ready;
    logic [1:0][DataW-1:0] req_data;
    logic [1:0]            req_data_v;
    logic [1:0]            req_dma_data_yumi_o;
    logic [PktW-1:0]       dma_pkt_o;
    logic                  dma_pkt_v_o;
    logic                  dma_pkt_yumi_i;
    logic [DataW-1:0]      dma_data_i;
    logic                  dma_data_v_i;
    logic                  dma_data_ready_and_o;
    logic [DataW-1:0]      dma_data_o;
    logic                  dma_data_v_o;
    logic                  dma_data_yumi_i;

    logic dram_accept;
    logic dram_wr_accept;

    // DRAM controller model: accepts only what is offered.
    assign dma_pkt_yumi_i  = dram_accept & dma_pkt_v_o;
    assign dma_data_yumi_i = dram_wr_accept & dma_data_v_o;

    int n_tests = 0;
    int n_fail  = 0;

    pkt_exp_t  pkt_q[$];
    beat_exp_t rd_q[$];
    beat_exp_t wr_q[$];

    pkt_exp_t  m_pkt;
    beat_exp_t m_beat;
    logic [1:0] m_oh;

    bp_dma_arbiter #(
        .dma_pkt_width_p(PktW),
        .data_width_p   (DataW),
        .block_width_p  (BlockW)
    ) dut (
        .clk_i                   (clk_i),
        .reset_i                 (reset_i),
        .req_dma_pkt_i           (req_pkt),
        .req_dma_pkt_v_i         (req_pkt_v),
        .req_dma_pkt_yumi_o      (req_dma_pkt_yumi_o),
        .req_dma_data_o          (req_dma_data_o),
        .req_dma_data_v_o        (req_dma_data_v_o),
        .req_dma_data_ready_and_i(req_ready),
        .req_dma_data_i          (req_data),
        .req_dma_data_v_i        (req_data_v),
        .req_dma_data_yumi_o     (req_dma_data_yumi_o),
        .dma_pkt_o               (dma_pkt_o),
        .dma_pkt_v_o             (dma_pkt_v_o),
        .dma_pkt_yumi_i          (dma_pkt_yumi_i),
        .dma_data_i              (dma_data_i),
        .dma_data_v_i            (dma_data_v_i),
        .dma_data_ready_and_o    (dma_data_ready_and_o),
        .dma_data_o              (dma_data_o),
        .dma_data_v_o            (dma_data_v_o),
        .dma_data_yumi_i         (dma_data_yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every handshake pops and checks the oldest expectation.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (dma_pkt_v_o && dma_pkt_yumi_i) begin
                if (pkt_q.size() == 0) begin
                    check_eq("pkt_unexpected", pkt_q.size(), 1);
                end else begin
                    m_pkt = pkt_q.pop_front();
                    m_oh  = 2'b01 << m_pkt.req;
                    check_eq("pkt_yumi", req_dma_pkt_yumi_o, m_oh);
                    check_eq("pkt_data", dma_pkt_o, m_pkt.pkt);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (req_dma_data_v_o[i] && req_ready[i]) begin
                    if (rd_q.size() == 0) begin
                        check_eq("rd_unexpected", rd_q.size(), 1);
                    end else begin
                        m_beat = rd_q.pop_front();
                        check_eq("rd_req", i, m_beat.req);
                        check_eq("rd_data", req_dma_data_o[i], m_beat.d);
                        check_eq("rd_ready", dma_data_ready_and_o, 1);
                    end
                end
            end
            if (dma_data_v_o && dma_data_yumi_i) begin
                if (wr_q.size() == 0) begin
                    check_eq("wr_unexpected", wr_q.size(), 1);
                end else begin
                    m_beat = wr_q.pop_front();
                    m_oh   = 2'b01 << m_beat.req;
                    check_eq("wr_data", dma_data_o, m_beat.d);
                    check_eq("wr_yumi", req_dma_data_yumi_o, m_oh);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_pkt(input bit r, input logic [PktW-1:0] pkt, input bit hold);
        pkt_exp_t e;
        bit       seen;
        e.req = r;
        e.pkt = pkt;
        pkt_q.push_back(e);
        req_pkt[r]   = pkt;
        req_pkt_v[r] = 1'b1;
        dram_accept  = 1'b1;
        seen         = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk_i);
            if (req_dma_pkt_yumi_o[r]) seen = 1'b1;
            step();
        end
        if (!hold) req_pkt_v[r] = 1'b0;
        dram_accept = 1'b0;
        if (!seen) check_eq("pkt_timeout", seen, 1);
    endtask

    task automatic read_beat(input bit r, input logic [DataW-1:0] d);
        beat_exp_t e;
        bit        seen;
        e.req = r;
        e.d   = d;
        rd_q.push_back(e);
        dma_data_v_i = 1'b1;
        dma_data_i   = d;
        seen         = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk_i);
            check_eq("rd_v_other", req_dma_data_v_o[!r], 0);
            if (dma_data_ready_and_o) seen = 1'b1;
            step();
        end
        dma_data_v_i = 1'b0;
        if (!seen) check_eq("rd_timeout", seen, 1);
    endtask

    // Two beats, optional stall before the second; ends after checking the idle cycle.
    task automatic read_beats(input bit r, input logic [DataW-1:0] d0, input logic [DataW-1:0] d1,
                              input int stall);
        read_beat(r, d0);
        if (stall > 0) begin
            req_ready[r] = 1'b0;
            dma_data_v_i = 1'b1;
            dma_data_i   = d1;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk_i);
                check_eq("bp_ready_low", dma_data_ready_and_o, 0);
                step();
            end
            req_ready[r] = 1'b1;
        end
        read_beat(r, d1);
        @(negedge clk_i);
        check_eq("idle_ready", dma_data_ready_and_o, 0);
        check_eq("idle_pkt_v", dma_pkt_v_o, |req_pkt_v);
        step();
    endtask

    task automatic write_beats(input bit r, input logic [DataW-1:0] d0, input logic [DataW-1:0] d1);
        beat_exp_t        e;
        bit               seen;
        logic [DataW-1:0] d[2];
        d[0]           = d0;
        d[1]           = d1;
        dram_wr_accept = 1'b1;
        for (int b = 0; b < 2; b++) begin
            e.req = r;
            e.d   = d[b];
            wr_q.push_back(e);
            req_data[r]   = d[b];
            req_data_v[r] = 1'b1;
            seen          = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk_i);
                check_eq("wr_yumi_other", req_dma_data_yumi_o[!r], 0);
                check_eq("pkt_yumi_busy", req_dma_pkt_yumi_o, 0);
                if (req_dma_data_yumi_o[r]) seen = 1'b1;
                step();
            end
            if (!seen) check_eq("wr_timeout", seen, 1);
        end
        req_data_v[r]  = 1'b0;
        dram_wr_accept = 1'b0;
    endtask

    // Reset with every input hot: all handshake outputs must stay low.
    task automatic reset_with_hot_inputs();
        req_pkt_v      = 2'b11;
        req_data_v     = 2'b11;
        req_ready      = 2'b11;
        dma_data_v_i   = 1'b1;
        dram_accept    = 1'b1;
        dram_wr_accept = 1'b1;
        reset_i        = 1'b1;
        @(negedge clk_i);
        check_eq("rst_pkt_v", dma_pkt_v_o, 0);
        check_eq("rst_pkt_yumi", req_dma_pkt_yumi_o, 0);
        check_eq("rst_rd_v", req_dma_data_v_o, 0);
        check_eq("rst_ready", dma_data_ready_and_o, 0);
        check_eq("rst_wr_v", dma_data_v_o, 0);
        check_eq("rst_wr_yumi", req_dma_data_yumi_o, 0);
        step();
        req_pkt_v      = 2'b00;
        req_data_v     = 2'b00;
        dma_data_v_i   = 1'b0;
        dram_accept    = 1'b0;
        dram_wr_accept = 1'b0;
        reset_i        = 1'b0;
        @(negedge clk_i);
        check_eq("post_rst_idle", dma_data_ready_and_o, 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i        = 1'b1;
        req_pkt        = '0;
        req_pkt_v      = '0;
        req_ready      = 2'b11;
        req_data       = '0;
        req_data_v     = '0;
        dma_data_i     = '0;
        dma_data_v_i   = 1'b0;
        dram_accept    = 1'b0;
        dram_wr_accept = 1'b0;
        step();
        reset_with_hot_inputs();

        // Contention: both requesters hold reads; grant must alternate 0,1,0,1.
        req_pkt[0] = {1'b0, 32'h9000_0000};
        req_pkt[1] = {1'b0, 32'h9000_1000};
        req_pkt_v  = 2'b11;
        for (int t = 0; t < 4; t++) begin
            send_pkt(t[0], req_pkt[t[0]], 1'b1);
            read_beats(t[0], 16'(16'hC000 + t * 2), 16'(16'hC001 + t * 2), 0);
        end
        req_pkt_v = 2'b00;

        // Single read by requester 0; requester 1 idles with a packet up but no accept.
        send_pkt(1'b0, {1'b0, 32'h8000_0040}, 1'b0);
        req_pkt[1]   = {1'b0, 32'h8000_0400};
        req_pkt_v[1] = 1'b1;
        read_beats(1'b0, 16'hAAAA, 16'hBBBB, 0);
        req_pkt_v[1] = 1'b0;

        // Write by requester 1 while requester 0 holds write data valid.
        req_data[0]   = 16'hDEAD;
        req_data_v[0] = 1'b1;
        send_pkt(1'b1, {1'b1, 32'h8000_0080}, 1'b0);
        write_beats(1'b1, 16'h1111, 16'h2222);
        req_data_v[0] = 1'b1;
        @(negedge clk_i);
        check_eq("wr_idle_no_yumi", req_dma_data_yumi_o, 0);
        step();
        req_data_v[0] = 1'b0;

        // Backpressure: requester 0 stalls 3 cycles before the second beat.
        send_pkt(1'b0, {1'b0, 32'h8000_00C0}, 1'b0);
        read_beats(1'b0, 16'h1234, 16'h5678, 3);

        // Blocking: requester 1's packet waits out requester 0's write.
        send_pkt(1'b0, {1'b1, 32'h8000_0200}, 1'b0);
        begin
            pkt_exp_t e;
            e.req = 1'b1;
            e.pkt = {1'b0, 32'h8000_0300};
            pkt_q.push_back(e);
        end
        req_pkt[1]   = {1'b0, 32'h8000_0300};
        req_pkt_v[1] = 1'b1;
        write_beats(1'b0, 16'h3333, 16'h4444);
        dram_accept = 1'b1;
        @(negedge clk_i);
        check_eq("blk_yumi_idle", req_dma_pkt_yumi_o, 2'b10);
        step();
        req_pkt_v[1] = 1'b0;
        dram_accept  = 1'b0;
        read_beats(1'b1, 16'h7777, 16'h8888, 0);

        // Reset after the first beat of a read, then a fresh read.
        send_pkt(1'b0, {1'b0, 32'h8000_0100}, 1'b0);
        read_beat(1'b0, 16'h5A5A);
        reset_with_hot_inputs();
        send_pkt(1'b1, {1'b0, 32'h8000_0500}, 1'b0);
        read_beats(1'b1, 16'h9999, 16'hEEEE, 0);

        check_eq("pkt_q_empty", pkt_q.size(), 0);
        check_eq("rd_q_empty", rd_q.size(), 0);
        check_eq("wr_q_empty", wr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
